// File: rtl/seg_scan_reader.sv
// Seven-segment scan reader: samples a multiplexed 7-segment display bus and
// turns it back into four hex digits. A pattern is captured only after it has
// been seen unchanged for STABLE_CYCLES samples. A digit held static is not
// captured again.
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   en           capture enable
//   seg[6:0]     segment lines a..g (seg[6]=a ... seg[0]=g), active high
//   dig_sel[3:0] one-hot digit select, bit k selects digit k
//   digits[15:0] decoded hex digits, digit k on [4k+3:4k]
//   digit_valid  per-digit flag: the digit holds a decoded value
//   upd          pulse: a capture changed digits/digit_valid
//   err          pulse: a stable non-blank pattern matched no hex code
//   frame_done   pulse: all four digits captured since the last frame/enable
//   out_en       en delayed by one cycle
module seg_scan_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        upd,
  output logic        err,
  output logic        frame_done,
  output logic        out_en
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned KEY_W = 11;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t           state, state_next;
  logic [KEY_W-1:0] samp, prev;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [3:0]       seen, seen_next;
  logic [15:0]      digits_next;
  logic [3:0]       valid_next;
  logic             upd_next, err_next, frame_next;
  logic             capture;
  logic [3:0]       samp_sel;
  logic [6:0]       samp_seg;
  logic             onehot, same;
  logic [4:0]       dec;

  // Segment pattern -> {hit, hex value}; hit=0 for blank or unknown patterns.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h7B:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  assign samp_sel = samp[10:7];
  assign samp_seg = samp[6:0];
  assign onehot   = $onehot(samp_sel);
  assign same     = (samp == prev);
  assign dec      = decode(samp_seg);

  // Next-state, stability counter and capture effects
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    capture     = 1'b0;
    seen_next   = seen;
    digits_next = digits;
    valid_next  = digit_valid;
    upd_next    = 1'b0;
    err_next    = 1'b0;
    frame_next  = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (en) state_next = TRACK;
      end
      TRACK: begin
        if (!onehot)                                cnt_next = '0;
        else if (!same)                             cnt_next = CNT_W'(1);
        else if (cnt == CNT_W'(STABLE_CYCLES))      capture  = en;
        else                                        cnt_next = cnt + CNT_W'(1);
        if (capture) state_next = HOLD;
      end
      HOLD: begin
        // Only a change of the sampled bus re-arms tracking.
        if (!same) begin
          state_next = TRACK;
          cnt_next   = onehot ? CNT_W'(1) : '0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!en) begin
      state_next = IDLE;
      seen_next  = '0;
    end

    if (capture) begin
      seen_next = seen | samp_sel;
      for (int k = 0; k < 4; k++) begin
        if (samp_sel[k]) begin
          if (dec[4]) begin
            digits_next[4*k +: 4] = dec[3:0];
            valid_next[k]         = 1'b1;
          end else begin
            // Blank keeps the old value silently; anything else is an error.
            valid_next[k] = 1'b0;
            err_next      = (samp_seg != 7'h00);
          end
        end
      end
      upd_next = (digits_next != digits) || (valid_next != digit_valid);
      if (seen_next == 4'hF) begin
        frame_next = 1'b1;
        seen_next  = '0;
      end
    end
  end

  // State, sample stage and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      samp        <= '0;
      prev        <= '0;
      cnt         <= '0;
      seen        <= '0;
      digits      <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      out_en      <= 1'b0;
    end else begin
      state       <= state_next;
      samp        <= {dig_sel, seg};
      prev        <= samp;
      cnt         <= cnt_next;
      seen        <= seen_next;
      digits      <= digits_next;
      digit_valid <= valid_next;
      upd         <= upd_next;
      err         <= err_next;
      frame_done  <= frame_next;
      out_en      <= en;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: directed vector table, hand-written
// corner sequences and a randomized phase, all compared cycle by cycle with a
// run-length reference model.
module tb_seg_scan_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd, err, frame_done, out_en;

  seg_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rstn(rstn), .en(en), .seg(seg), .dig_sel(dig_sel),
    .digits(digits), .digit_valid(digit_valid), .upd(upd), .err(err),
    .frame_done(frame_done), .out_en(out_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int c_upd, c_err, c_frame;

  // Reference model state
  logic [6:0]  codes [16];
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_seen;
  logic        m_upd, m_err, m_frame, m_out_en;
  logic [10:0] m_key;
  logic        m_last_en, m_captured;
  int          m_run;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    int         hold;
    logic [3:0] exp_dig;
    logic       exp_vld;
    int         exp_upd;
    int         exp_err;
    int         exp_frame;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_seen = '0;
    m_upd = 1'b0; m_err = 1'b0; m_frame = 1'b0; m_out_en = 1'b0;
    m_key = '0; m_last_en = 1'b0; m_captured = 1'b0; m_run = 0;
  endtask

  // A digit is taken once an enabled run of identical samples reaches S+1
  // samples (S stable comparisons plus the sample stage), once per run.
  task automatic model_step();
    logic [10:0] key;
    logic        cap;
    logic [3:0]  sel_r;
    logic [6:0]  seg_r;
    logic [15:0] od;
    logic [3:0]  ov;
    int          hit;
    int          slot;
    key = {dig_sel, seg};
    m_upd = 1'b0; m_err = 1'b0; m_frame = 1'b0;
    sel_r = m_key[10:7];
    seg_r = m_key[6:0];
    cap = en && (m_run >= S + 1) && !m_captured && ($countones(sel_r) == 1);
    if (cap) begin
      od = m_digits; ov = m_valid; hit = -1; slot = 0;
      for (int i = 0; i < 16; i++) if (codes[i] == seg_r) hit = i;
      for (int b = 0; b < 4; b++) if (sel_r[b]) slot = b;
      if (hit >= 0) begin
        m_digits[4*slot +: 4] = 4'(hit);
        m_valid[slot] = 1'b1;
      end else begin
        m_valid[slot] = 1'b0;
        m_err = (seg_r != 7'h00);
      end
      m_upd = (od != m_digits) || (ov != m_valid);
      m_seen = m_seen | sel_r;
      if (m_seen == 4'hF) begin
        m_frame = 1'b1;
        m_seen = '0;
      end
    end
    if (!en) m_seen = '0;
    if (en && m_last_en && key == m_key) begin
      if (m_run < 1000) m_run++;
      m_captured = m_captured | cap;
    end else begin
      m_run = en ? 1 : 0;
      m_captured = 1'b0;
    end
    m_key = key; m_last_en = en; m_out_en = en;
  endtask

  // One clock: update the model on the edge, compare just after it.
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    #1;
    check("digits", 32'(digits), 32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("upd", 32'(upd), 32'(m_upd));
    check("err", 32'(err), 32'(m_err));
    check("frame_done", 32'(frame_done), 32'(m_frame));
    check("out_en", 32'(out_en), 32'(m_out_en));
    c_upd += int'(upd);
    c_err += int'(err);
    c_frame += int'(frame_done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_upd"}, 32'(upd), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_frame"}, 32'(frame_done), 32'h0);
    check({tag, "_out_en"}, 32'(out_en), 32'h0);
  endtask

  initial begin
    int slot;
    codes = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    vecs[0] = '{4'b0001, 7'h79, 8, 4'h3, 1'b1, 1, 0, 0};
    vecs[1] = '{4'b0010, 7'h33, 8, 4'h4, 1'b1, 1, 0, 0};
    vecs[2] = '{4'b0100, 7'h77, 8, 4'hA, 1'b1, 1, 0, 0};
    vecs[3] = '{4'b1000, 7'h3D, 8, 4'hD, 1'b1, 1, 0, 1};
    vecs[4] = '{4'b0100, 7'h55, 8, 4'hA, 1'b0, 1, 1, 0};
    vecs[5] = '{4'b0100, 7'h00, 8, 4'hA, 1'b0, 0, 0, 0};
    vecs[6] = '{4'b0100, 7'h5F, 8, 4'h6, 1'b1, 1, 0, 0};
    vecs[7] = '{4'b0100, 7'h5F, 8, 4'h6, 1'b1, 0, 0, 0};
    vecs[8] = '{4'b0001, 7'h7E, 8, 4'h0, 1'b1, 1, 0, 0};
    vecs[9] = '{4'b0010, 7'h00, 8, 4'h4, 1'b0, 1, 0, 0};

    rstn = 1'b0; en = 1'b0; seg = '0; dig_sel = '0;
    c_upd = 0; c_err = 0; c_frame = 0;
    model_reset();
    @(posedge clk); #1;
    check_zero("reset");
    tick();
    rstn = 1'b1;
    tick(); tick();

    // Single digit: capture latency S+1 from the first presenting edge
    en = 1'b1; dig_sel = 4'b0001; seg = 7'h6D;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("lat_upd_%0d", k), 32'(upd), 32'(k == 5));
    end
    check("lat_digit0", 32'(digits[3:0]), 32'h2);
    check("lat_valid", 32'(digit_valid), 32'h1);

    // Vector table: frame of four digits, invalid, blank, static recapture
    foreach (vecs[i]) begin
      c_upd = 0; c_err = 0; c_frame = 0;
      dig_sel = vecs[i].sel; seg = vecs[i].seg;
      for (int k = 0; k < vecs[i].hold; k++) tick();
      slot = 0;
      for (int b = 0; b < 4; b++) if (vecs[i].sel[b]) slot = b;
      check($sformatf("vec%0d_digit", i), 32'(digits[4*slot +: 4]), 32'(vecs[i].exp_dig));
      check($sformatf("vec%0d_valid", i), 32'(digit_valid[slot]), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_upd", i), 32'(c_upd), 32'(vecs[i].exp_upd));
      check($sformatf("vec%0d_err", i), 32'(c_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_frame", i), 32'(c_frame), 32'(vecs[i].exp_frame));
      if (i == 3) begin
        check("frame_digits", 32'(digits), 32'hDA43);
        check("frame_valid", 32'(digit_valid), 32'hF);
      end
    end

    // Toggling faster than the stability window never captures
    c_upd = 0;
    dig_sel = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      seg = (c % 2 == 0) ? 7'h30 : 7'h7E;
      for (int k = 0; k < 3; k++) tick();
    end
    check("toggle_upd", 32'(c_upd), 32'h0);
    check("toggle_valid", 32'(digit_valid), 32'hD);

    // Non-one-hot select, then enable dropped mid-window
    c_upd = 0; c_err = 0; c_frame = 0;
    dig_sel = 4'b0011; seg = 7'h7E;
    for (int k = 0; k < 10; k++) tick();
    check("multi_upd", 32'(c_upd), 32'h0);
    check("multi_err", 32'(c_err), 32'h0);
    check("multi_digits", 32'(digits), 32'hD640);
    dig_sel = 4'b0001; seg = 7'h30;
    for (int k = 0; k < 3; k++) tick();
    check("pre_drop_out_en", 32'(out_en), 32'h1);
    en = 1'b0;
    tick();
    check("drop_out_en", 32'(out_en), 32'h0);
    for (int k = 0; k < 6; k++) tick();
    check("idle_upd", 32'(c_upd), 32'h0);
    check("idle_digits", 32'(digits), 32'hD640);
    check("idle_valid", 32'(digit_valid), 32'hD);

    // Reset in the middle of a stable window
    en = 1'b1; dig_sel = 4'b0010; seg = 7'h5F;
    for (int k = 0; k < 3; k++) tick();
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check_zero("midrst");
    tick(); tick();
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rst_upd_%0d", k), 32'(upd), 32'(k == 5));
    end
    check("rst_digits", 32'(digits), 32'h0060);
    check("rst_valid", 32'(digit_valid), 32'h2);

    // Randomized segments against the model
    for (int n = 0; n < 60; n++) begin
      int r;
      en = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      if (r < 8)       dig_sel = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) dig_sel = 4'b0000;
      else             dig_sel = 4'b0101;
      r = $urandom_range(0, 9);
      if (r < 7)       seg = codes[$urandom_range(0, 15)];
      else if (r == 7) seg = 7'h00;
      else             seg = 7'($urandom);
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 The block SHALL have one parameter, STABLE_CYCLES, default 4 (range 2..15): the number of consecutive identical samples required before a digit is captured.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: capture enable, active high.
REQ-005 The block SHALL have port seg, input, 7 bits: segment lines, active high, with seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f and seg[0]=g.
REQ-006 The block SHALL have port dig_sel, input, 4 bits: multiplexed digit select, one-hot, active high; bit k selects digit k.
REQ-007 The block SHALL have port digits, output, 16 bits: reconstructed hex values, with digit k on bits [4k+3:4k].
REQ-008 The block SHALL have port digit_valid, output, 4 bits: bit k high means digits[4k+3:4k] holds a decoded value.
REQ-009 The block SHALL have port upd, output, 1 bit: one-cycle pulse on every capture that changes digits or digit_valid.
REQ-010 The block SHALL have port err, output, 1 bit: one-cycle pulse when a stable, non-blank pattern matches no hex code.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when all four digits have been captured since the previous frame_done or the start of enable.
REQ-012 The block SHALL have port out_en, output, 1 bit: registered copy of en, delayed by one cycle.

Function
REQ-013 The block SHALL register seg and dig_sel once (sample stage); all comparisons SHALL use these registered copies.
REQ-014 The block SHALL implement the FSM states IDLE, TRACK and HOLD.
REQ-015 In IDLE, transition to TRACK SHALL occur when en=1; from any state, en=0 SHALL force IDLE on the next edge.
REQ-016 In TRACK, the stability counter SHALL increment when the sampled {dig_sel,seg} equals the previous sample, and SHALL reload to 1 otherwise.
REQ-017 Capture SHALL occur in the cycle the counter reaches STABLE_CYCLES while dig_sel is one-hot, after which the FSM SHALL enter HOLD.
REQ-018 A non-one-hot dig_sel (0000 or two or more bits set) SHALL hold the counter at 0 and produce no capture.
REQ-019 HOLD SHALL return to TRACK, with the counter at 1, on any change of sampled {dig_sel,seg}; a digit held static SHALL NOT be recaptured.
REQ-020 Decode SHALL use the table 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
REQ-021 On a capture of a valid pattern, digits[k] SHALL take the decoded value and digit_valid[k] SHALL be set to 1.
REQ-022 On a capture of a blank pattern (seg=00), digit_valid[k] SHALL be cleared to 0, digits[k] SHALL be left unchanged, and err SHALL NOT pulse.
REQ-023 On a capture of any other pattern, digit_valid[k] SHALL be cleared to 0 and err SHALL pulse.
REQ-024 upd SHALL pulse only when the new {digits[k], digit_valid[k]} differs from the old value.
REQ-025 The block SHALL keep a 4-bit seen mask, setting bit k on any capture of digit k; when the mask reaches 1111, frame_done SHALL pulse and the mask SHALL clear in the same cycle.
REQ-026 The mask SHALL also clear on entry to IDLE.
REQ-027 Capture latency SHALL be STABLE_CYCLES+1 clocks from the first edge presenting a new stable input to the outputs updating (one sample stage plus the counter).
REQ-028 digits and digit_valid SHALL retain their values across IDLE; only reset SHALL clear them.
REQ-029 The stability counter SHALL saturate at STABLE_CYCLES and SHALL never wrap.

Reset
REQ-030 While rstn=0, outputs SHALL immediately be digits=0000, digit_valid=0000, upd=0, err=0, frame_done=0 and out_en=0, the FSM SHALL be in IDLE, and the counter, mask and sample registers SHALL be 0.
REQ-031 Reset asserted mid-capture SHALL abort the capture without any pulse.
REQ-032 After rstn rises, the first capture SHALL require a full STABLE_CYCLES stable window.

Verification
REQ-033 The bench SHALL cover: en=1, dig_sel=0001, seg=6D held for 6 cycles -> digits[3:0]=2, digit_valid=0001 and one upd pulse exactly 5 clocks after the first presented edge.
REQ-034 The bench SHALL cover: dig_sel cycling through 0001, 0010, 0100, 1000 with 79, 33, 77, 3D, each held 8 cycles -> digits=D A 4 3 (hex 16'hDA43), digit_valid=1111 and one frame_done pulse on the fourth capture.
REQ-035 The bench SHALL cover: seg toggling 30/7E every 3 cycles with STABLE_CYCLES=4 -> no capture, upd=0 throughout.
REQ-036 The bench SHALL cover: dig_sel=0100, seg=55 held -> one err pulse, digit_valid[2]=0; then seg=00 -> no err, digit_valid[2] stays 0.
REQ-037 The bench SHALL cover: dig_sel=0011 held 10 cycles -> no capture; en dropped mid-window -> IDLE, out_en=0 one cycle later, digits retained.
REQ-038 The bench SHALL cover: rstn pulsed low during the stable window of a 5F pattern -> all outputs 0 immediately, with no upd afterwards until a new full window completes.
